// File: rtl/reg_writeback_unit.sv
// Write-side master for the register file's single write port: merges MEM/WB
// results with buffered long-latency results and reports pending writes.
module reg_writeback_unit #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_valid_i,
  input  logic [4:0]    pipe_rd_i,
  input  logic [31:0]   pipe_data_i,
  input  logic          lat_valid_i,
  input  logic [4:0]    lat_rd_i,
  input  logic [31:0]   lat_data_i,
  output logic          lat_ready_o,
  output logic          rf_we_o,
  output logic [4:0]    rf_rd_o,
  output logic [31:0]   rf_din_o,
  input  logic [4:0]    q_rs1_i,
  input  logic [4:0]    q_rs2_i,
  output logic          q_hit1_o,
  output logic          q_hit2_o,
  output logic [CW-1:0] pend_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_din_q, rf_din_d;

  logic pipe_wr, push, pop;

  assign lat_ready_o  = !reset && (count_q < DEPTH_C);
  assign rf_we_o      = rf_we_q;
  assign rf_rd_o      = rf_rd_q;
  assign rf_din_o     = rf_din_q;
  assign pend_count_o = count_q;

  // Port arbitration: a pipe write with a real destination always wins.
  always_comb begin
    pipe_wr  = pipe_valid_i && (pipe_rd_i != 5'd0);
    pop      = !pipe_wr && (count_q != '0);
    push     = lat_valid_i && lat_ready_o && (lat_rd_i != 5'd0);
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (pipe_wr) begin
      rf_we_d  = 1'b1;
      rf_rd_d  = pipe_rd_i;
      rf_din_d = pipe_data_i;
    end else if (pop) begin
      rf_we_d  = 1'b1;
      rf_rd_d  = rd_mem[head_q];
      rf_din_d = data_mem[head_q];
    end
  end

  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pending-write query covers buffered entries and the write now on the port.
  always_comb begin
    q_hit1_o = rf_we_q && (rf_rd_q == q_rs1_i);
    q_hit2_o = rf_we_q && (rf_rd_q == q_rs2_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_mem[i] == q_rs1_i)) q_hit1_o = 1'b1;
      if (vld_q[i] && (rd_mem[i] == q_rs2_i)) q_hit2_o = 1'b1;
    end
    if (q_rs1_i == 5'd0) q_hit1_o = 1'b0;
    if (q_rs2_i == 5'd0) q_hit2_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= 5'd0;
      rf_din_q <= 32'd0;
    end else begin
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_din_q <= rf_din_d;
    end
  end

  // Entry storage carries no reset; validity lives in vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= lat_rd_i;
      data_mem[tail_q] <= lat_data_i;
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed + random bench for reg_writeback_unit with a queue-based scoreboard.
module tb_reg_writeback_unit;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pipe_valid = 1'b0;
  logic [4:0]    pipe_rd = '0;
  logic [31:0]   pipe_data = '0;
  logic          lat_valid = 1'b0;
  logic [4:0]    lat_rd = '0;
  logic [31:0]   lat_data = '0;
  logic          lat_ready;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_din;
  logic [4:0]    q_rs1 = '0;
  logic [4:0]    q_rs2 = '0;
  logic          q_hit1, q_hit2;
  logic [CW-1:0] pend_count;

  reg_writeback_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid_i(pipe_valid), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .lat_valid_i(lat_valid), .lat_rd_i(lat_rd), .lat_data_i(lat_data),
    .lat_ready_o(lat_ready),
    .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_din_o(rf_din),
    .q_rs1_i(q_rs1), .q_rs2_i(q_rs2), .q_hit1_o(q_hit1), .q_hit2_o(q_hit2),
    .pend_count_o(pend_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [4:0]    rd;
    logic [31:0]   din;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t mq[$];
  logic        mwe;
  logic [4:0]  mrd;
  logic [31:0] mdin;
  logic        last_acc;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic model_hit(input logic [4:0] rs);
    logic h;
    h = mwe && (mrd == rs);
    foreach (mq[i]) if (mq[i].rd == rs) h = 1'b1;
    return (rs != 5'd0) && h;
  endfunction

  // One clock: drive at negedge, check combinational outputs, predict, check after edge.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic mready;
    exp_t e, got;
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    lat_valid = lv; lat_rd = lrd; lat_data = ld;
    #1;
    mready = (mq.size() < DEPTH);
    chk("lat_ready", lat_ready, mready);
    chk("q_hit1", q_hit1, model_hit(q_rs1));
    chk("q_hit2", q_hit2, model_hit(q_rs2));
    last_acc = lv && mready;
    if (pv && prd != 5'd0) begin
      mwe = 1'b1; mrd = prd; mdin = pd;
    end else if (mq.size() > 0) begin
      ent_t h;
      h = mq.pop_front();
      mwe = 1'b1; mrd = h.rd; mdin = h.data;
    end else begin
      mwe = 1'b0;
    end
    if (lv && mready && lrd != 5'd0) mq.push_back('{rd: lrd, data: ld});
    e.we = mwe; e.rd = mrd; e.din = mdin; e.cnt = CW'(mq.size());
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("rf_we", rf_we, got.we);
    chk("rf_rd", rf_rd, got.rd);
    chk("rf_din", rf_din, got.din);
    chk("pend_count", pend_count, got.cnt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h5555_0000;
    lat_valid = 1'b1; lat_rd = 5'd9; lat_data = 32'h99;
    #1;
    chk("lat_ready_in_reset", lat_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_rd", rf_rd, 5'd0);
    chk("rst_rf_din", rf_din, 32'd0);
    chk("rst_pend", pend_count, '0);
    mq.delete(); mwe = 1'b0; mrd = '0; mdin = '0;
    @(negedge clk);
    reset = 1'b0;
    pipe_valid = 1'b0; lat_valid = 1'b0;
  endtask

  initial begin
    int idx;
    int guard;
    logic [4:0] hold_rd;
    logic [31:0] hold_d;
    logic hold_v;
    @(negedge clk);
    do_reset();

    // Single pipe write, then idle.
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Long-latency result on an idle port; query its destination.
    q_rs1 = 5'd7;
    step(0, 0, 0, 1, 5'd7, 32'h11);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    q_rs1 = 5'd0;

    // Three results while the pipe owns the port every cycle.
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1, 5'd3, 32'h3000 + c, (idx < 3), 5'd8 + 5'(idx), 32'h800 + idx);
      if (last_acc) idx++;
    end
    chk("accepted_while_blocked", idx, 2);
    guard = 0;
    while ((idx < 3 || mq.size() > 0 || mwe) && guard < 20) begin
      step(0, 0, 0, (idx < 3), 5'd8 + 5'(idx), 32'h800 + idx);
      if (last_acc) idx++;
      guard++;
    end
    chk("drain_bound", guard < 20, 1'b1);

    // Zero destinations never claim the port or the FIFO.
    step(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB);
    step(0, 0, 0, 0, 0, 0);

    // Fill FIFO behind the pipe, then reset discards it.
    step(1, 5'd3, 32'h1, 1, 5'd4, 32'h44);
    step(1, 5'd3, 32'h2, 1, 5'd6, 32'h66);
    do_reset();
    q_rs1 = 5'd4; q_rs2 = 5'd6;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    q_rs1 = 5'd0; q_rs2 = 5'd0;

    // Same-edge push and pop at count 1, repeated across pointer wrap.
    step(1, 5'd3, 32'h1, 1, 5'd12, 32'hC);
    step(0, 0, 0, 1, 5'd13, 32'hD);
    step(0, 0, 0, 1, 5'd14, 32'hE);
    step(0, 0, 0, 1, 5'd15, 32'hF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic; the producer holds an offer until it is accepted.
    hold_v = 1'b0; hold_rd = '0; hold_d = '0;
    for (int t = 0; t < 20; t++) begin
      if (!hold_v) begin
        hold_v = ($urandom_range(0, 2) != 0);
        hold_rd = 5'($urandom_range(0, 31));
        hold_d = $urandom;
      end
      q_rs1 = 5'($urandom_range(0, 31));
      q_rs2 = hold_rd;
      step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           hold_v, hold_rd, hold_d);
      if (last_acc) hold_v = 1'b0;
    end
    for (int t = 0; t < 4; t++) step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
